// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer for the five-stage CPU.
// It decides the PC and pipeline-register write enables and bubble flushes each
// cycle, runs a data-memory wait watchdog and counts PC-stall cycles.
// Ports:
//   clk, clrn                     clock, async active-low reset
//   D_Rs, D_Rt, D_UseRs, D_UseRt  D-stage source operands
//   D_BranchTaken                 D-stage taken branch/jump
//   E_M2Reg, E_RegWrite, E_TargetReg  E-stage load / writeback info
//   M_MemAccess, M_MemReady       M-stage data-memory handshake
//   I_Ready                       instruction fetch completes this cycle
//   PC_en..MW_en                  register write enables (combinational)
//   FD_flush, DE_flush, MW_flush  bubble inserts (combinational)
//   BusErr                        sticky data-memory timeout flag (registered)
//   StallCnt                      cycles with PC_en=0 (registered)
module pipe_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       D_Rs,
  input  logic [4:0]       D_Rt,
  input  logic             D_UseRs,
  input  logic             D_UseRt,
  input  logic             D_BranchTaken,
  input  logic             E_M2Reg,
  input  logic             E_RegWrite,
  input  logic [4:0]       E_TargetReg,
  input  logic             M_MemAccess,
  input  logic             M_MemReady,
  input  logic             I_Ready,
  output logic             PC_en,
  output logic             FD_en,
  output logic             DE_en,
  output logic             EM_en,
  output logic             MW_en,
  output logic             FD_flush,
  output logic             DE_flush,
  output logic             MW_flush,
  output logic             BusErr,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, DWAIT, ERR} state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic              bus_err_nx;
  logic [CNT_W-1:0]  stall_cnt_nx;
  logic              dstall, lu, istall;

  // Hazard terms
  assign dstall = M_MemAccess & ~M_MemReady;
  assign istall = ~I_Ready;
  assign lu     = E_M2Reg & E_RegWrite & (E_TargetReg != 5'd0) &
                  ((D_UseRs & (D_Rs == E_TargetReg)) |
                   (D_UseRt & (D_Rt == E_TargetReg)));

  // State, watchdog and counter registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= RUN;
      wait_cnt <= '0;
      BusErr   <= 1'b0;
      StallCnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      BusErr   <= bus_err_nx;
      StallCnt <= stall_cnt_nx;
    end
  end

  // Zero-latency enables/flushes, first matching hazard wins
  always_comb begin
    PC_en    = 1'b1;
    FD_en    = 1'b1;
    DE_en    = 1'b1;
    EM_en    = 1'b1;
    MW_en    = 1'b1;
    FD_flush = 1'b0;
    DE_flush = 1'b0;
    MW_flush = 1'b0;
    if (!clrn) begin
      // Hold everything and fill the pipe with bubbles while in reset
      PC_en    = 1'b0;
      FD_en    = 1'b0;
      DE_en    = 1'b0;
      EM_en    = 1'b0;
      MW_en    = 1'b0;
      FD_flush = 1'b1;
      DE_flush = 1'b1;
      MW_flush = 1'b1;
    end else if (state == ERR) begin
      PC_en = 1'b0;
      FD_en = 1'b0;
      DE_en = 1'b0;
      EM_en = 1'b0;
      MW_en = 1'b0;
    end else if (dstall) begin
      // M holds; W gets a bubble so the register file is not written twice
      PC_en    = 1'b0;
      FD_en    = 1'b0;
      DE_en    = 1'b0;
      EM_en    = 1'b0;
      MW_flush = 1'b1;
    end else if (lu || (istall && D_BranchTaken)) begin
      PC_en    = 1'b0;
      FD_en    = 1'b0;
      DE_flush = 1'b1;
    end else if (istall) begin
      PC_en    = 1'b0;
      FD_flush = 1'b1;
    end else if (D_BranchTaken) begin
      FD_flush = 1'b1;
    end
  end

  // Next-state: data-wait watchdog and stall counter
  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    bus_err_nx   = BusErr;
    stall_cnt_nx = StallCnt;
    case (state)
      RUN: begin
        if (dstall) begin
          state_nx    = DWAIT;
          wait_cnt_nx = WAIT_W'(1);
        end
      end
      DWAIT: begin
        if (!dstall) begin
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
          state_nx   = ERR;
          bus_err_nx = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + WAIT_W'(1);
        end
      end
      ERR: ;
      default: state_nx = RUN;
    endcase
    if ((state != ERR) && !PC_en)
      stall_cnt_nx = StallCnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 16;

  logic             clk;
  logic             clrn;
  logic [4:0]       D_Rs, D_Rt, E_TargetReg;
  logic             D_UseRs, D_UseRt, D_BranchTaken;
  logic             E_M2Reg, E_RegWrite;
  logic             M_MemAccess, M_MemReady, I_Ready;
  logic             PC_en, FD_en, DE_en, EM_en, MW_en;
  logic             FD_flush, DE_flush, MW_flush;
  logic             BusErr;
  logic [CNT_W-1:0] StallCnt;
  logic [7:0]       ctrl;

  pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
    .D_BranchTaken(D_BranchTaken),
    .E_M2Reg(E_M2Reg), .E_RegWrite(E_RegWrite), .E_TargetReg(E_TargetReg),
    .M_MemAccess(M_MemAccess), .M_MemReady(M_MemReady), .I_Ready(I_Ready),
    .PC_en(PC_en), .FD_en(FD_en), .DE_en(DE_en), .EM_en(EM_en), .MW_en(MW_en),
    .FD_flush(FD_flush), .DE_flush(DE_flush), .MW_flush(MW_flush),
    .BusErr(BusErr), .StallCnt(StallCnt)
  );

  assign ctrl = {PC_en, FD_en, DE_en, EM_en, MW_en, FD_flush, DE_flush, MW_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control words {PC,FD,DE,EM,MW,FDf,DEf,MWf}
  localparam logic [7:0] C_RUN  = 8'b11111_000;
  localparam logic [7:0] C_DST  = 8'b00001_001;
  localparam logic [7:0] C_LU   = 8'b00111_010;
  localparam logic [7:0] C_IST  = 8'b01111_100;
  localparam logic [7:0] C_BR   = 8'b11111_100;
  localparam logic [7:0] C_ERR  = 8'b00000_000;
  localparam logic [7:0] C_RST  = 8'b00000_111;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, br, m2r, rw;
    logic [4:0] tgt;
    logic       macc, mrdy, irdy;
    logic [7:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: error flag, length of the current data-wait run, stall count
  bit               m_err;
  int               m_run;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_ctrl();
    bit ds, lu, is;
    if (!clrn) return C_RST;
    if (m_err) return C_ERR;
    ds = M_MemAccess && !M_MemReady;
    lu = E_M2Reg && E_RegWrite && (E_TargetReg != 5'd0) &&
         ((D_UseRs && D_Rs == E_TargetReg) || (D_UseRt && D_Rt == E_TargetReg));
    is = !I_Ready;
    if (ds) return C_DST;
    if (lu || (is && D_BranchTaken)) return C_LU;
    if (is) return C_IST;
    if (D_BranchTaken) return C_BR;
    return C_RUN;
  endfunction

  // Advance the model across one rising edge (clrn high)
  task automatic model_step(input logic pc);
    if (!m_err) begin
      if (!pc) m_cnt = m_cnt + 1'b1;
      if (M_MemAccess && !M_MemReady) begin
        m_run++;
        if (m_run > int'(TIMEOUT)) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // One clock: check at negedge (against table value when given, else model)
  task automatic cycle(input string nm, input bit use_t, input logic [7:0] texp);
    logic [7:0] e;
    @(negedge clk);
    e = use_t ? texp : ref_ctrl();
    chk({nm, "_ctrl"}, 32'(ctrl), 32'(e));
    chk({nm, "_buserr"}, 32'(BusErr), 32'(m_err));
    chk({nm, "_stallcnt"}, 32'(StallCnt), 32'(m_cnt));
    @(posedge clk);
    model_step(e[7]);
    #1;
  endtask

  // Asynchronous reset pulse mid-cycle
  task automatic do_reset();
    #2 clrn = 1'b0;
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
    chk("rst_stallcnt", 32'(StallCnt), 32'd0);
    chk("rst_buserr", 32'(BusErr), 32'd0);
    m_err = 1'b0;
    m_run = 0;
    m_cnt = '0;
    @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  task automatic quiet();
    D_Rs = 5'd1; D_Rt = 5'd2; D_UseRs = 1'b1; D_UseRt = 1'b1; D_BranchTaken = 1'b0;
    E_M2Reg = 1'b0; E_RegWrite = 1'b0; E_TargetReg = 5'd0;
    M_MemAccess = 1'b0; M_MemReady = 1'b1; I_Ready = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    D_Rs = v.rs; D_Rt = v.rt; D_UseRs = v.urs; D_UseRt = v.urt;
    D_BranchTaken = v.br; E_M2Reg = v.m2r; E_RegWrite = v.rw;
    E_TargetReg = v.tgt; M_MemAccess = v.macc; M_MemReady = v.mrdy;
    I_Ready = v.irdy;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             tbl[13];
    logic [CNT_W-1:0] s0;
    int               burst;

    //        rs     rt     urs   urt   br    m2r   rw    tgt    macc  mrdy  irdy  exp
    tbl[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, C_RUN};
    tbl[1]  = '{5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, C_LU};
    tbl[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, C_RUN};
    tbl[3]  = '{5'd5, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, C_RUN};
    tbl[4]  = '{5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, C_LU};
    tbl[5]  = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, C_RUN};
    tbl[6]  = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, C_RUN};
    tbl[7]  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_LU};
    tbl[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_IST};
    tbl[9]  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_BR};
    tbl[10] = '{5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_DST};
    tbl[11] = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_RUN};
    tbl[12] = '{5'd3, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, C_LU};

    // Power-on reset
    quiet();
    clrn  = 1'b0;
    m_err = 1'b0; m_run = 0; m_cnt = '0;
    #1;
    chk("por_ctrl", 32'(ctrl), 32'(C_RST));
    chk("por_stallcnt", 32'(StallCnt), 32'd0);
    chk("por_buserr", 32'(BusErr), 32'd0);
    @(posedge clk);
    #1 clrn = 1'b1;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i]);
      cycle($sformatf("vec%0d", i), 1'b1, tbl[i].exp);
    end

    // Load-use: one bubble then the pipeline advances
    quiet();
    s0 = m_cnt;
    E_M2Reg = 1'b1; E_RegWrite = 1'b1; E_TargetReg = 5'd5; D_Rs = 5'd5;
    cycle("lu", 1'b1, C_LU);
    quiet();
    cycle("lu_after", 1'b1, C_RUN);
    chk("lu_stallcnt", 32'(StallCnt), 32'(s0 + 1'b1));

    // Three-cycle data wait
    s0 = m_cnt;
    M_MemAccess = 1'b1; M_MemReady = 1'b0;
    for (int i = 0; i < 3; i++) cycle("dwait", 1'b1, C_DST);
    M_MemReady = 1'b1;
    cycle("dwait_done", 1'b1, C_RUN);
    chk("dwait_stallcnt", 32'(StallCnt), 32'(s0 + 3'd3));
    chk("dwait_buserr", 32'(BusErr), 32'd0);

    // Wait of exactly TIMEOUT cycles completes without error
    M_MemReady = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) cycle("tmo_edge", 1'b1, C_DST);
    M_MemReady = 1'b1;
    cycle("tmo_edge_done", 1'b1, C_RUN);
    chk("tmo_edge_buserr", 32'(BusErr), 32'd0);

    // Timeout: BusErr after the (TIMEOUT+1)th stalled edge, then frozen
    M_MemReady = 1'b0;
    for (int i = 0; i <= int'(TIMEOUT); i++) cycle("tmo", 1'b1, C_DST);
    chk("tmo_buserr", 32'(BusErr), 32'd1);
    s0 = m_cnt;
    quiet();
    D_BranchTaken = 1'b1; I_Ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("err_frozen", 1'b1, C_ERR);
    chk("err_stallcnt", 32'(StallCnt), 32'(s0));
    chk("err_sticky", 32'(BusErr), 32'd1);
    do_reset();
    quiet();
    cycle("post_err", 1'b1, C_RUN);

    // Fetch wait with a taken branch
    D_BranchTaken = 1'b1; I_Ready = 1'b0;
    cycle("br_ifwait", 1'b1, C_LU);
    I_Ready = 1'b1;
    cycle("br_ifdone", 1'b1, C_BR);

    // Reset in the middle of a data wait
    quiet();
    M_MemAccess = 1'b1; M_MemReady = 1'b0;
    cycle("rst_dw1", 1'b1, C_DST);
    cycle("rst_dw2", 1'b1, C_DST);
    do_reset();
    quiet();
    cycle("rst_dw_after", 1'b1, C_RUN);
    chk("rst_dw_buserr", 32'(BusErr), 32'd0);

    // Randomized traffic against the model
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      D_Rs          = 5'($urandom_range(0, 3));
      D_Rt          = 5'($urandom_range(0, 3));
      D_UseRs       = 1'($urandom);
      D_UseRt       = 1'($urandom);
      D_BranchTaken = ($urandom_range(0, 3) == 0);
      E_M2Reg       = 1'($urandom);
      E_RegWrite    = ($urandom_range(0, 3) != 0);
      E_TargetReg   = 5'($urandom_range(0, 3));
      I_Ready       = ($urandom_range(0, 3) != 0);
      if (burst == 0 && $urandom_range(0, 40) == 0) burst = $urandom_range(3, 7);
      if (burst > 0) begin
        M_MemAccess = 1'b1; M_MemReady = 1'b0; burst--;
      end else begin
        M_MemAccess = 1'($urandom);
        M_MemReady  = ($urandom_range(0, 2) != 0);
      end
      if ((m_err && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0) begin
        burst = 0;
        do_reset();
      end else begin
        cycle("rand", 1'b0, 8'h00);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
